ad9280_decimator: RTL and testbench
===================================

Name: ad9280_decimator

Overview:
- Upstream of the trigger/sample-capture stage. Reduces the raw AD9280 8-bit stream by a power-of-two ratio.
- Produces a single-cycle `deci_valid` strobe and the matching `deci_data` byte.
- `deci_data` drives the capture stage's `ad_data` input; `deci_valid` drives its `deci_valid` input.
- Four reduction modes: plain sample, peak-max, peak-min and box average. This lets the scope show slow timebases without aliasing narrow glitches.

Parameters:
- MAX_LOG2, 10: largest decimation exponent supported. Ratio is 2^rate_log2, at most 1024.
- ACC_W, 8+MAX_LOG2: accumulator width for average mode.

Ports:
- ad_clk  in  1  ADC sample clock. One ADC sample per cycle.
- rst  in  1  Reset, asynchronous, active-high.
- ad_data  in  8  Raw ADC sample, unsigned.
- deci_en  in  1  Decimation run enable.
- rate_log2  in  4  Decimation exponent k. Ratio N = 2^k.
- deci_mode  in  2  Reduction mode: 0 = SAMPLE, 1 = PEAK_MAX, 2 = PEAK_MIN, 3 = AVERAGE.
- deci_valid  out  1  One-cycle strobe; a reduced sample is available.
- deci_data  out  8  Reduced sample. Held between strobes.
- cfg_restart  out  1  One-cycle pulse when a configuration change aborted a window.

Behaviour:
- Reset (async, rst=1) clears:
  - deci_valid=0, deci_data=0, cfg_restart=0;
  - window counter cnt=0, accumulator=0, max_reg=0x00, min_reg=0xFF;
  - registered config copy = k0 (clamped rate_log2) and deci_mode.
- Effective exponent: ke = min(rate_log2, MAX_LOG2). Values above MAX_LOG2 are clamped, not wrapped.
- Window: N = 2^ke consecutive accepted samples. A sample is accepted on every ad_clk edge with deci_en=1.
- cnt counts 0..N-1.
  - Accepted sample with cnt<N-1: cnt increments and the reducer state updates.
  - Accepted sample with cnt==N-1: on the same edge, deci_valid<=1 and deci_data<=result including that final sample. cnt<=0 and the reducer state reloads to idle values.
  - Latency is therefore one cycle from the last window sample to the strobe.
- deci_valid is high for exactly one cycle per window, never back-to-back, except when N=1.
- Reducer results:
  - SAMPLE: last sample of the window.
  - PEAK_MAX: maximum over the window.
  - PEAK_MIN: minimum over the window.
  - AVERAGE: floor(sum/N), i.e. the ACC_W-bit sum shifted right by ke. No rounding; the sum cannot overflow.
- ke=0 (N=1): every accepted sample produces deci_valid=1 the next cycle with deci_data = ad_data, in all modes. deci_valid stays high continuously while deci_en=1.
- deci_en=0:
  - No accept; cnt and reducer state hold.
  - deci_valid=0 next cycle; deci_data holds.
  - The window resumes when deci_en returns to 1, so partial windows span the gap.
- Config change: when ke or deci_mode differs from the registered copy, in any cycle and regardless of deci_en:
  - the copy updates, cnt<=0, reducer state reloads;
  - cfg_restart=1 for one cycle; no strobe is issued for the aborted partial window.
  - The sample in the change cycle is discarded. The first sample of the new window is the next accepted one.
- A config change on the same edge that would complete a window takes priority: no strobe.
- Reset mid-window: immediate return to reset values. The first strobe after release comes N accepted samples later.
- A change in ad_data alone never affects cnt.

Decomposition:
- Shared package dso_pkg:
  - deci_mode encodings: DECI_SAMPLE, DECI_PEAK_MAX, DECI_PEAK_MIN, DECI_AVG;
  - DECI_MAX_LOG2 = 10;
  - ADC_W = 8.
- Sub-module deci_reduce:
  - holds accumulator, max_reg and min_reg;
  - inputs: sample, accept, reload, mode, ke;
  - output: combinational result including the current sample.
- The top module owns cnt, config tracking and the output registers.

Test Plan:
- Pass-through: rate_log2=0, mode=SAMPLE, ramp 0,1,2,… with deci_en=1 → deci_valid high every cycle; deci_data lags ad_data by one cycle (0,1,2,…).
- Sample mode: k=2, ramp 0..15 → four strobes with deci_data 3, 7, 11, 15; strobe one cycle after samples 3, 7, 11, 15.
- Peak and average: k=2, window 10,200,30,41:
  - PEAK_MAX → 200;
  - PEAK_MIN → 10;
  - AVERAGE → 70 (281>>2).
- Average with k=10, constant 0xFF → strobe every 1024 cycles with 0xFF, proving no overflow. Then rate_log2=15 → identical behaviour (clamped to 10).
- Config change: k=3, switch mode after 5 samples → cfg_restart pulse, no strobe; the next strobe arrives 8 accepted samples after the change cycle. Separately, change the mode on the window-completing edge → no strobe.
- Enable gap and reset: k=2; deci_en low for 3 cycles after sample 2 → the strobe follows the 4th accepted sample and deci_data holds during the gap. Assert rst mid-window → outputs 0 immediately; the first strobe after release comes 4 samples later.

Source files
------------

// File: rtl/dso_pkg.sv
// ---------------------------------------------------------------------------
// dso_pkg
// Shared definitions for the oscilloscope front end: ADC sample width,
// largest supported decimation exponent, reduction-mode encodings and a
// helper that clamps a requested decimation exponent.
// ---------------------------------------------------------------------------
package dso_pkg;

    localparam int ADC_W         = 8;
    localparam int DECI_MAX_LOG2 = 10;

    typedef enum logic [1:0] {
        DECI_SAMPLE   = 2'd0,
        DECI_PEAK_MAX = 2'd1,
        DECI_PEAK_MIN = 2'd2,
        DECI_AVG      = 2'd3
    } deci_mode_t;

    // Requested exponents above the supported maximum saturate, never wrap.
    function automatic logic [3:0] clamp_ke(input logic [3:0] rate,
                                            input logic [3:0] kmax);
        logic [3:0] ke;
        if (rate > kmax) begin
            ke = kmax;
        end else begin
            ke = rate;
        end
        return ke;
    endfunction

endpackage

// File: rtl/deci_reduce.sv
// ---------------------------------------------------------------------------
// deci_reduce
// Window reducer for the AD9280 decimator. Keeps a running sum, a running
// maximum and a running minimum of the samples accepted so far in the
// current window and presents, combinationally, the reduced value that the
// window would have if the current sample were its last one.
//
// Ports:
//   clk     in   sample clock
//   rst     in   asynchronous active-high reset
//   sample  in   current ADC sample
//   accept  in   fold the current sample into the running state
//   reload  in   return the running state to its idle values (wins over accept)
//   mode    in   reduction mode (dso_pkg::deci_mode_t encoding)
//   ke      in   effective decimation exponent (window = 2^ke samples)
//   result  out  reduced value including the current sample
// ---------------------------------------------------------------------------
module deci_reduce
    import dso_pkg::*;
#(
    parameter int MAX_LOG2 = DECI_MAX_LOG2,
    parameter int ACC_W    = ADC_W + MAX_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] sample,
    input  logic             accept,
    input  logic             reload,
    input  logic [1:0]       mode,
    input  logic [3:0]       ke,
    output logic [ADC_W-1:0] result
);

    logic [ACC_W-1:0] acc_r;
    logic [ADC_W-1:0] max_r;
    logic [ADC_W-1:0] min_r;

    logic [ACC_W-1:0] sum_s;
    logic [ADC_W-1:0] max_s;
    logic [ADC_W-1:0] min_s;
    logic [ADC_W-1:0] avg_s;

    // Running statistics extended by the current sample.
    always_comb begin
        sum_s = acc_r + ACC_W'(sample);
        if (sample > max_r) begin
            max_s = sample;
        end else begin
            max_s = max_r;
        end
        if (sample < min_r) begin
            min_s = sample;
        end else begin
            min_s = min_r;
        end
        // A full window of 2^ke samples averaged by shifting: floor, no rounding.
        avg_s = ADC_W'(sum_s >> ke);
    end

    // Select the reduced value for the active mode.
    always_comb begin
        case (deci_mode_t'(mode))
            DECI_SAMPLE:   result = sample;
            DECI_PEAK_MAX: result = max_s;
            DECI_PEAK_MIN: result = min_s;
            DECI_AVG:      result = avg_s;
            default:       result = sample;
        endcase
    end

    // Running state: idle values are sum 0, max 0x00 and min 0xFF so the
    // first accepted sample of a window always replaces the extremes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            max_r <= {ADC_W{1'b0}};
            min_r <= {ADC_W{1'b1}};
        end else if (reload) begin
            acc_r <= {ACC_W{1'b0}};
            max_r <= {ADC_W{1'b0}};
            min_r <= {ADC_W{1'b1}};
        end else if (accept) begin
            acc_r <= sum_s;
            max_r <= max_s;
            min_r <= min_s;
        end
    end

endmodule

// File: rtl/ad9280_decimator.sv
// ---------------------------------------------------------------------------
// ad9280_decimator
// Reduces the raw AD9280 8-bit sample stream by 2^k (k clamped to MAX_LOG2)
// using one of four reductions: plain sample, peak-max, peak-min or box
// average. Each completed window yields a one-cycle deci_valid strobe with
// the reduced byte on deci_data, which then holds until the next strobe.
// Any change of the effective exponent or the mode aborts the current
// window and raises cfg_restart for one cycle.
//
// Ports:
//   ad_clk       in   ADC sample clock, one sample per cycle
//   rst          in   asynchronous active-high reset
//   ad_data      in   raw unsigned ADC sample
//   deci_en      in   accept a sample on this edge
//   rate_log2    in   requested decimation exponent k (ratio 2^k)
//   deci_mode    in   reduction mode (0 sample, 1 max, 2 min, 3 average)
//   deci_valid   out  one-cycle strobe, reduced sample available
//   deci_data    out  reduced sample, held between strobes
//   cfg_restart  out  one-cycle pulse, configuration change aborted a window
// ---------------------------------------------------------------------------
module ad9280_decimator
    import dso_pkg::*;
#(
    parameter int MAX_LOG2 = DECI_MAX_LOG2,
    parameter int ACC_W    = ADC_W + MAX_LOG2
) (
    input  logic             ad_clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] ad_data,
    input  logic             deci_en,
    input  logic [3:0]       rate_log2,
    input  logic [1:0]       deci_mode,
    output logic             deci_valid,
    output logic [ADC_W-1:0] deci_data,
    output logic             cfg_restart
);

    localparam int         CNT_W  = MAX_LOG2;
    localparam logic [3:0] KE_MAX = 4'(MAX_LOG2);

    logic [3:0]       ke_s;
    logic [3:0]       cfg_ke_r;
    logic [1:0]       cfg_mode_r;
    logic [CNT_W-1:0] cnt_r;

    logic [CNT_W:0]   span_s;
    logic [CNT_W-1:0] last_s;
    logic             cfg_change_s;
    logic             accept_s;
    logic             win_done_s;
    logic             reload_s;
    logic [ADC_W-1:0] result_s;

    // Window bookkeeping. The window runs on the registered configuration,
    // so a change is detected against the copy and handled before any
    // sample is accepted under the new settings.
    always_comb begin
        ke_s         = clamp_ke(rate_log2, KE_MAX);
        span_s       = (CNT_W + 1)'(1) << cfg_ke_r;
        last_s       = CNT_W'(span_s - (CNT_W + 1)'(1));
        cfg_change_s = (ke_s != cfg_ke_r) || (deci_mode != cfg_mode_r);
        // The sample present during a configuration change is discarded.
        accept_s     = deci_en & ~cfg_change_s;
        win_done_s   = accept_s & (cnt_r == last_s);
        reload_s     = cfg_change_s | win_done_s;
    end

    deci_reduce #(
        .MAX_LOG2 (MAX_LOG2),
        .ACC_W    (ACC_W)
    ) u_reduce (
        .clk    (ad_clk),
        .rst    (rst),
        .sample (ad_data),
        .accept (accept_s),
        .reload (reload_s),
        .mode   (cfg_mode_r),
        .ke     (cfg_ke_r),
        .result (result_s)
    );

    // Configuration copy, window counter and registered outputs. The
    // configuration copy resets to the live inputs so that leaving reset
    // with an unchanged setup does not look like a reconfiguration.
    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            cfg_ke_r    <= ke_s;
            cfg_mode_r  <= deci_mode;
            cnt_r       <= {CNT_W{1'b0}};
            deci_valid  <= 1'b0;
            deci_data   <= {ADC_W{1'b0}};
            cfg_restart <= 1'b0;
        end else if (cfg_change_s) begin
            // Abort takes priority over a window that would complete now.
            cfg_ke_r    <= ke_s;
            cfg_mode_r  <= deci_mode;
            cnt_r       <= {CNT_W{1'b0}};
            deci_valid  <= 1'b0;
            cfg_restart <= 1'b1;
        end else if (win_done_s) begin
            cnt_r       <= {CNT_W{1'b0}};
            deci_valid  <= 1'b1;
            deci_data   <= result_s;
            cfg_restart <= 1'b0;
        end else if (accept_s) begin
            cnt_r       <= cnt_r + CNT_W'(1);
            deci_valid  <= 1'b0;
            cfg_restart <= 1'b0;
        end else begin
            // Enable gap: window position and deci_data hold.
            deci_valid  <= 1'b0;
            cfg_restart <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad9280_decimator.sv
// ---------------------------------------------------------------------------
// tb_ad9280_decimator
// Directed bench for ad9280_decimator. A window model built on a queue of
// accepted samples predicts deci_valid / deci_data / cfg_restart for every
// cycle; literal expectations per scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_ad9280_decimator;

    logic       ad_clk = 1'b0;
    logic       rst;
    logic [7:0] ad_data;
    logic       deci_en;
    logic [3:0] rate_log2;
    logic [1:0] deci_mode;
    logic       deci_valid;
    logic [7:0] deci_data;
    logic       cfg_restart;

    ad9280_decimator dut (
        .ad_clk      (ad_clk),
        .rst         (rst),
        .ad_data     (ad_data),
        .deci_en     (deci_en),
        .rate_log2   (rate_log2),
        .deci_mode   (deci_mode),
        .deci_valid  (deci_valid),
        .deci_data   (deci_data),
        .cfg_restart (cfg_restart)
    );

    always #5 ad_clk = ~ad_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int cur_rate = 0;
    int cur_mode = 0;

    // Model state
    int win[$];
    int m_ke   = 0;
    int m_mode = 0;
    int m_tmp_ke;
    int m_res;
    int m_sum;
    int exp_valid   = 0;
    int exp_data    = 0;
    int exp_restart = 0;

    // Observed strobes for literal checks
    int strobes[$];
    int n_restart = 0;

    task automatic check(input string name, input int got, input int expv);
        n_cmp = n_cmp + 1;
        if (got != expv) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, expv);
        end
    endtask

    // Expected strobe list: n values first, first+step, first+2*step, ...
    task automatic check_strobes(input string name, input int n, input int first, input int step);
        check({name, "_count"}, strobes.size(), n);
        for (int i = 0; i < n; i++) begin
            check({name, "_data"}, (i < strobes.size()) ? strobes[i] : -1, first + step * i);
        end
    endtask

    function automatic int clampi(input int r);
        return (r > 10) ? 10 : r;
    endfunction

    // Window model: a window is simply the list of samples accepted since
    // the last strobe/abort; it completes when it holds 2^ke samples.
    always @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            win.delete();
            m_ke        = clampi(int'(rate_log2));
            m_mode      = int'(deci_mode);
            exp_valid   = 0;
            exp_data    = 0;
            exp_restart = 0;
        end else begin
            m_tmp_ke    = clampi(int'(rate_log2));
            exp_valid   = 0;
            exp_restart = 0;
            if (m_tmp_ke != m_ke || int'(deci_mode) != m_mode) begin
                m_ke        = m_tmp_ke;
                m_mode      = int'(deci_mode);
                win.delete();
                exp_restart = 1;
            end else if (deci_en) begin
                win.push_back(int'(ad_data));
                if (win.size() == (1 << m_ke)) begin
                    case (m_mode)
                        0: m_res = win[win.size() - 1];
                        1: begin
                            m_res = 0;
                            foreach (win[i]) if (win[i] > m_res) m_res = win[i];
                        end
                        2: begin
                            m_res = 255;
                            foreach (win[i]) if (win[i] < m_res) m_res = win[i];
                        end
                        default: begin
                            m_sum = 0;
                            foreach (win[i]) m_sum = m_sum + win[i];
                            m_res = m_sum / win.size();
                        end
                    endcase
                    exp_valid = 1;
                    exp_data  = m_res;
                    win.delete();
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge ad_clk) begin
        check("valid", int'(deci_valid), exp_valid);
        check("data", int'(deci_data), exp_data);
        check("restart", int'(cfg_restart), exp_restart);
        if (deci_valid) strobes.push_back(int'(deci_data));
        if (cfg_restart) n_restart = n_restart + 1;
    end

    // Present one cycle of inputs; returns just after the sampling edge.
    task automatic apply(input int d, input bit en);
        ad_data   = 8'(d);
        deci_en   = en;
        rate_log2 = 4'(cur_rate);
        deci_mode = 2'(cur_mode);
        @(posedge ad_clk);
        #2;
    endtask

    task automatic reconfig(input int rate, input int mode);
        cur_rate = rate;
        cur_mode = mode;
        apply(0, 1'b0);
        apply(0, 1'b0);
        strobes.delete();
        n_restart = 0;
    endtask

    initial begin
        rst       = 1'b1;
        ad_data   = 8'd0;
        deci_en   = 1'b0;
        rate_log2 = 4'd0;
        deci_mode = 2'd0;
        apply(0, 1'b0);
        apply(0, 1'b0);
        check("reset_valid", int'(deci_valid), 0);
        check("reset_data", int'(deci_data), 0);
        rst = 1'b0;
        apply(0, 1'b0);
        strobes.delete();
        n_restart = 0;

        // Pass-through, k=0
        for (int i = 0; i < 8; i++) apply(i, 1'b1);
        apply(0, 1'b0);
        check_strobes("pass", 8, 0, 1);
        check("pass_restart", n_restart, 0);

        // Sample mode, k=2, ramp 0..15
        reconfig(2, 0);
        for (int i = 0; i < 16; i++) apply(i, 1'b1);
        apply(0, 1'b0);
        check_strobes("sample", 4, 3, 4);

        // Peak and average over 10,200,30,41
        for (int m = 1; m < 4; m++) begin
            reconfig(2, m);
            apply(10, 1'b1);
            apply(200, 1'b1);
            apply(30, 1'b1);
            apply(41, 1'b1);
            apply(0, 1'b0);
            case (m)
                1:       check_strobes("peak_max", 1, 200, 0);
                2:       check_strobes("peak_min", 1, 10, 0);
                default: check_strobes("average", 1, 70, 0);
            endcase
        end

        // Average, k=10, constant 0xFF; then rate 15 clamps to the same k
        reconfig(10, 3);
        for (int i = 0; i < 2048; i++) apply(255, 1'b1);
        apply(0, 1'b0);
        check_strobes("avg1024", 2, 255, 0);
        strobes.delete();
        n_restart = 0;
        cur_rate = 15;
        for (int i = 0; i < 1024; i++) apply(255, 1'b1);
        apply(0, 1'b0);
        check_strobes("avg_clamp", 1, 255, 0);
        check("avg_clamp_restart", n_restart, 0);

        // Mode change mid-window, k=3
        reconfig(3, 1);
        for (int i = 1; i <= 5; i++) apply(i, 1'b1);
        cur_mode = 3;
        apply(99, 1'b1);
        for (int i = 10; i <= 17; i++) apply(i, 1'b1);
        apply(0, 1'b0);
        check_strobes("abort_mid", 1, 13, 0);
        check("abort_mid_restart", n_restart, 1);

        // Mode change on the window-completing edge
        strobes.delete();
        n_restart = 0;
        for (int i = 0; i < 7; i++) apply(100 + i, 1'b1);
        cur_mode = 1;
        apply(50, 1'b1);
        apply(0, 1'b0);
        check("abort_edge_strobes", strobes.size(), 0);
        for (int i = 0; i < 8; i++) apply(i, 1'b1);
        apply(0, 1'b0);
        check_strobes("abort_edge", 1, 7, 0);
        check("abort_edge_restart", n_restart, 1);

        // Enable gap, k=2
        reconfig(2, 0);
        apply(5, 1'b1);
        apply(6, 1'b1);
        apply(7, 1'b1);
        for (int i = 0; i < 3; i++) apply(0, 1'b0);
        apply(8, 1'b1);
        apply(0, 1'b0);
        check_strobes("gap", 1, 8, 0);

        // Reset mid-window
        apply(1, 1'b1);
        apply(2, 1'b1);
        rst = 1'b1;
        @(negedge ad_clk);
        check("rst_mid_valid", int'(deci_valid), 0);
        check("rst_mid_data", int'(deci_data), 0);
        check("rst_mid_restart", int'(cfg_restart), 0);
        @(posedge ad_clk);
        #2;
        rst = 1'b0;
        apply(0, 1'b0);
        strobes.delete();
        for (int i = 20; i <= 22; i++) apply(i, 1'b1);
        apply(0, 1'b0);
        check("rst_early_strobes", strobes.size(), 0);
        apply(23, 1'b1);
        apply(0, 1'b0);
        check_strobes("rst_after", 1, 23, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
